// File: rtl/traffic_ctrl_param_if.sv
`default_nettype none
// ============================================================================
// Module      : traffic_ctrl_param_if
// Description : Pedestrian request inputs plus lamp and walk outputs of the
//               intersection controller.
// Revision    : 1.0
// ============================================================================
interface traffic_ctrl_param_if;
    logic ped_NS;
    logic ped_EW;
    logic ns_red;
    logic ns_yellow;
    logic ns_green;
    logic ew_red;
    logic ew_yellow;
    logic ew_green;
    logic walk_NS;
    logic walk_EW;
    logic ped_wait;

    modport master (
        output ped_NS, ped_EW,
        input  ns_red, ns_yellow, ns_green,
        input  ew_red, ew_yellow, ew_green,
        input  walk_NS, walk_EW, ped_wait
    );

    modport slave (
        input  ped_NS, ped_EW,
        output ns_red, ns_yellow, ns_green,
        output ew_red, ew_yellow, ew_green,
        output walk_NS, walk_EW, ped_wait
    );
endinterface
`default_nettype wire

// File: rtl/traffic_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : traffic_ctrl_param
// Description : Two-way intersection controller with pedestrian walk latches
//               and early green termination on an opposing request.
// Revision    : 1.0
// ============================================================================
module traffic_ctrl_param #(
    parameter int MIN_GREEN   = 10,
    parameter int MAX_GREEN   = 40,
    parameter int YELLOW_TIME = 4,
    parameter int ALLRED_TIME = 2,
    parameter int WALK_TIME   = 6,
    parameter int CNT_W       = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    traffic_ctrl_param_if.slave   bus
);

    typedef enum logic [2:0] {
        S_NS_GREEN  = 3'd0,
        S_NS_YELLOW = 3'd1,
        S_RED1      = 3'd2,
        S_EW_GREEN  = 3'd3,
        S_EW_YELLOW = 3'd4,
        S_RED2      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] C_MIN_LAST  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] C_MAX_LAST  = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] C_MAX       = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] C_YEL_LAST  = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] C_AR_LAST   = CNT_W'(ALLRED_TIME - 1);
    localparam logic [CNT_W-1:0] C_WALK_LAST = CNT_W'(WALK_TIME - 1);

    // Lamp vector order: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
    localparam logic [5:0] C_LAMP_NSG = 6'b001_100;
    localparam logic [5:0] C_LAMP_NSY = 6'b010_100;
    localparam logic [5:0] C_LAMP_RED = 6'b100_100;
    localparam logic [5:0] C_LAMP_EWG = 6'b100_001;
    localparam logic [5:0] C_LAMP_EWY = 6'b100_010;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic               req_ns_q, req_ns_d;
    logic               req_ew_q, req_ew_d;
    logic               walk_ns_q, walk_ns_d;
    logic               walk_ew_q, walk_ew_d;
    logic               ped_wait_q, ped_wait_d;
    logic [5:0]         lamps_q, lamps_d;

    logic               w_enter;
    logic               w_enter_ns;
    logic               w_enter_ew;
    logic               w_want_ns;
    logic               w_want_ew;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        lamps_d    = C_LAMP_NSG;
        w_want_ns  = req_ns_q | bus.ped_NS;
        w_want_ew  = req_ew_q | bus.ped_EW;

        // The raw request counts as "observed" in the same cycle, so a
        // pulse late in green ends it at the end of that very cycle.
        case (state_q)
            S_NS_GREEN:  if (timer_q == C_MAX_LAST || (w_want_ew && timer_q >= C_MIN_LAST))
                             state_d = S_NS_YELLOW;
            S_NS_YELLOW: if (timer_q == C_YEL_LAST) state_d = S_RED1;
            S_RED1:      if (timer_q == C_AR_LAST)  state_d = S_EW_GREEN;
            S_EW_GREEN:  if (timer_q == C_MAX_LAST || (w_want_ns && timer_q >= C_MIN_LAST))
                             state_d = S_EW_YELLOW;
            S_EW_YELLOW: if (timer_q == C_YEL_LAST) state_d = S_RED2;
            S_RED2:      if (timer_q == C_AR_LAST)  state_d = S_NS_GREEN;
            default:     state_d = S_NS_GREEN;
        endcase

        w_enter    = (state_d != state_q);
        w_enter_ns = w_enter && (state_d == S_NS_GREEN);
        w_enter_ew = w_enter && (state_d == S_EW_GREEN);

        if (w_enter)
            timer_d = '0;
        else if (timer_q != C_MAX)
            timer_d = timer_q + 1'b1;

        // Clearing on green entry beats a simultaneous set; a held button
        // re-latches on the following edge and waits for the next green.
        req_ns_d   = w_enter_ns ? 1'b0 : w_want_ns;
        req_ew_d   = w_enter_ew ? 1'b0 : w_want_ew;
        ped_wait_d = req_ns_d | req_ew_d;

        walk_ns_d  = w_enter_ns ? w_want_ns
                   : (walk_ns_q && state_d == S_NS_GREEN && timer_q < C_WALK_LAST);
        walk_ew_d  = w_enter_ew ? w_want_ew
                   : (walk_ew_q && state_d == S_EW_GREEN && timer_q < C_WALK_LAST);

        case (state_d)
            S_NS_GREEN:  lamps_d = C_LAMP_NSG;
            S_NS_YELLOW: lamps_d = C_LAMP_NSY;
            S_EW_GREEN:  lamps_d = C_LAMP_EWG;
            S_EW_YELLOW: lamps_d = C_LAMP_EWY;
            default:     lamps_d = C_LAMP_RED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_NS_GREEN;
            timer_q    <= '0;
            req_ns_q   <= 1'b0;
            req_ew_q   <= 1'b0;
            walk_ns_q  <= 1'b0;
            walk_ew_q  <= 1'b0;
            ped_wait_q <= 1'b0;
            lamps_q    <= C_LAMP_NSG;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            req_ns_q   <= req_ns_d;
            req_ew_q   <= req_ew_d;
            walk_ns_q  <= walk_ns_d;
            walk_ew_q  <= walk_ew_d;
            ped_wait_q <= ped_wait_d;
            lamps_q    <= lamps_d;
        end
    end

    assign bus.ns_red    = lamps_q[5];
    assign bus.ns_yellow = lamps_q[4];
    assign bus.ns_green  = lamps_q[3];
    assign bus.ew_red    = lamps_q[2];
    assign bus.ew_yellow = lamps_q[1];
    assign bus.ew_green  = lamps_q[0];
    assign bus.walk_NS   = walk_ns_q;
    assign bus.walk_EW   = walk_ew_q;
    assign bus.ped_wait  = ped_wait_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_ctrl_param
// Description : Directed-vector bench for the intersection controller.
// Revision    : 1.0
// ============================================================================
module tb_traffic_ctrl_param;

    localparam logic [5:0] NSG = 6'b001_100;
    localparam logic [5:0] NSY = 6'b010_100;
    localparam logic [5:0] RED = 6'b100_100;
    localparam logic [5:0] EWG = 6'b100_001;
    localparam logic [5:0] EWY = 6'b100_010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;
    int   viol    = 0;
    logic mon_en  = 1'b0;

    traffic_ctrl_param_if bus();

    traffic_ctrl_param u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    wire [5:0] lamps = {bus.ns_red, bus.ns_yellow, bus.ns_green,
                        bus.ew_red, bus.ew_yellow, bus.ew_green};

    // Safety invariants sampled every cycle once the DUT is out of X.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!$onehot(lamps[5:3]))                 viol++;
            if (!$onehot(lamps[2:0]))                 viol++;
            if (!bus.ns_red && !bus.ew_red)           viol++;
            if (bus.walk_NS && bus.walk_EW)           viol++;
            if (bus.walk_NS && !bus.ns_green)         viol++;
            if (bus.walk_EW && !bus.ew_green)         viol++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Leaves the bench at the negedge of the first NS_GREEN cycle (timer 0).
    task automatic do_reset();
        bus.ped_NS = 1'b0;
        bus.ped_EW = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    // Called at a negedge inside the phase; returns at the first negedge past it.
    task automatic run_len(input logic [5:0] pat, output int n);
        n = 0;
        while (lamps == pat && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic walk_len(input logic ns, output int n);
        n = 0;
        while ((ns ? bus.walk_NS : bus.walk_EW) && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got=0 exp=1");
        $fatal(1, "timeout");
    end

    initial begin
        int n, w, total;
        bus.ped_NS = 1'b0;
        bus.ped_EW = 1'b0;

        // Reset values and free-running cycle with no requests.
        do_reset();
        chk("rst_lamps", lamps, NSG);
        chk("rst_walk", {bus.walk_NS, bus.walk_EW}, 0);
        chk("rst_pwait", bus.ped_wait, 0);
        total = 0;
        run_len(NSG, n); chk("free_nsg", n, 40); total += n;
        run_len(NSY, n); chk("free_nsy", n, 4);  total += n;
        run_len(RED, n); chk("free_r1", n, 2);   total += n;
        run_len(EWG, n); chk("free_ewg", n, 40); total += n;
        run_len(EWY, n); chk("free_ewy", n, 4);  total += n;
        run_len(RED, n); chk("free_r2", n, 2);   total += n;
        chk("free_period", total, 92);
        chk("free_back_nsg", lamps, NSG);

        // ped_EW pulse at NS timer 3: green cut to MIN_GREEN, EW walk served.
        do_reset();
        repeat (3) @(negedge clk);
        bus.ped_EW = 1'b1;
        @(negedge clk);
        bus.ped_EW = 1'b0;
        chk("p3_pwait", bus.ped_wait, 1);
        run_len(NSG, n); chk("p3_nsg", n + 4, 10);
        run_len(NSY, n); chk("p3_nsy", n, 4);
        run_len(RED, n); chk("p3_r1", n, 2);
        chk("p3_ewg_start", lamps, EWG);
        walk_len(1'b0, w); chk("p3_walk_ew", w, 6);
        chk("p3_pwait_low", bus.ped_wait, 0);
        run_len(EWG, n); chk("p3_ewg", n + 6, 40);

        // ped_EW pulse at NS timer 25: green ends at end of that cycle.
        do_reset();
        repeat (25) @(negedge clk);
        chk("p25_still_g", lamps, NSG);
        bus.ped_EW = 1'b1;
        @(negedge clk);
        bus.ped_EW = 1'b0;
        chk("p25_yellow", lamps, NSY);

        // Simultaneous requests during NS green.
        do_reset();
        repeat (2) @(negedge clk);
        bus.ped_NS = 1'b1;
        bus.ped_EW = 1'b1;
        @(negedge clk);
        bus.ped_NS = 1'b0;
        bus.ped_EW = 1'b0;
        chk("both_no_ns_walk", bus.walk_NS, 0);
        run_len(NSG, n); chk("both_nsg", n + 3, 10);
        run_len(NSY, n);
        run_len(RED, n);
        chk("both_ew_walk", {bus.walk_NS, bus.walk_EW}, 2'b01);
        chk("both_pwait_ew", bus.ped_wait, 1);
        run_len(EWG, n); chk("both_ewg", n, 10);
        run_len(EWY, n);
        run_len(RED, n);
        chk("both_ns_walk", {bus.walk_NS, bus.walk_EW}, 2'b10);
        chk("both_pwait_end", bus.ped_wait, 0);

        // ped_NS held: full NS green, EW cut short, walk_NS on every NS green.
        do_reset();
        bus.ped_NS = 1'b1;
        run_len(NSG, n); chk("hold_nsg1", n, 40);
        run_len(NSY, n);
        run_len(RED, n);
        chk("hold_pwait", bus.ped_wait, 1);
        run_len(EWG, n); chk("hold_ewg", n, 10);
        run_len(EWY, n);
        run_len(RED, n);
        walk_len(1'b1, w); chk("hold_walk_ns", w, 6);
        chk("hold_relatch", bus.ped_wait, 1);
        run_len(NSG, n); chk("hold_nsg2", n + 6, 40);
        run_len(NSY, n);
        run_len(RED, n);
        run_len(EWG, n);
        run_len(EWY, n);
        run_len(RED, n);
        walk_len(1'b1, w); chk("hold_walk_ns2", w, 6);
        bus.ped_NS = 1'b0;

        // Reset during EW_YELLOW with an NS request pending.
        do_reset();
        run_len(NSG, n);
        run_len(NSY, n);
        run_len(RED, n);
        bus.ped_NS = 1'b1;
        @(negedge clk);
        bus.ped_NS = 1'b0;
        run_len(EWG, n); chk("ry_ewg", n + 1, 10);
        chk("ry_in_yellow", lamps, EWY);
        chk("ry_pwait", bus.ped_wait, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("ry_lamps", lamps, NSG);
        chk("ry_walk", {bus.walk_NS, bus.walk_EW}, 0);
        chk("ry_pwait0", bus.ped_wait, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("ry_no_req", bus.ped_wait, 0);

        chk("invariants", viol, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
